// File: rtl/carry_save_adder3_if.sv
// Operand/result bundle for carry_save_adder3.
// The master drives operands and observes results; the slave is the adder.
interface carry_save_adder3_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic [WIDTH:0]   s;
  logic             carry;
  logic             out_valid;

  modport master (
    output in_valid, x, y, z,
    input  s, carry, out_valid
  );

  modport slave (
    input  in_valid, x, y, z,
    output s, carry, out_valid
  );
endinterface

// File: rtl/carry_save_adder3.sv
// Three-operand unsigned adder: carry-save row, then ripple carry-propagate, registered result.
// Define CSA_PIPE_EN to register ps/cv between the two stages (latency 2 instead of 1).
module carry_save_adder3 #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  carry_save_adder3_if.slave   bus
);

  localparam int SW = WIDTH + 2;

  // Carry-save row: one full adder per bit, carries shifted up by one.
  logic [WIDTH-1:0] ps;
  logic [WIDTH:0]   cv;

  assign cv[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_csa
      assign ps[gi]   = bus.x[gi] ^ bus.y[gi] ^ bus.z[gi];
      assign cv[gi+1] = (bus.x[gi] & bus.y[gi]) |
                        (bus.x[gi] & bus.z[gi]) |
                        (bus.y[gi] & bus.z[gi]);
    end
  endgenerate

  logic [WIDTH-1:0] cpa_ps;
  logic [WIDTH:0]   cpa_cv;
  logic             cpa_valid;

`ifdef CSA_PIPE_EN
  logic [WIDTH-1:0] ps_d, ps_q;
  logic [WIDTH:0]   cv_d, cv_q;
  logic             stage_valid_d, stage_valid_q;

  // Vectors only load on valid cycles so undriven operands never reach the CPA.
  always_comb begin
    ps_d          = ps_q;
    cv_d          = cv_q;
    stage_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      ps_d = ps;
      cv_d = cv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q          <= '0;
      cv_q          <= '0;
      stage_valid_q <= 1'b0;
    end else begin
      ps_q          <= ps_d;
      cv_q          <= cv_d;
      stage_valid_q <= stage_valid_d;
    end
  end

  assign cpa_ps    = ps_q;
  assign cpa_cv    = cv_q;
  assign cpa_valid = stage_valid_q;
`else
  assign cpa_ps    = ps;
  assign cpa_cv    = cv;
  assign cpa_valid = bus.in_valid;
`endif

  // Ripple carry-propagate over zero-extended vectors, carry-in 0.
  logic [SW-1:0] cpa_a;
  logic [SW-1:0] cpa_b;
  logic          cpa_c;
  logic [SW-1:0] sum_full;

  always_comb begin
    cpa_a    = {2'b00, cpa_ps};
    cpa_b    = {1'b0, cpa_cv};
    cpa_c    = 1'b0;
    sum_full = '0;
    for (int i = 0; i < SW; i++) begin
      sum_full[i] = cpa_a[i] ^ cpa_b[i] ^ cpa_c;
      cpa_c       = (cpa_a[i] & cpa_b[i]) | (cpa_a[i] & cpa_c) | (cpa_b[i] & cpa_c);
    end
  end

  logic [WIDTH:0] s_d, s_q;
  logic           carry_d, carry_q;
  logic           out_valid_d, out_valid_q;

  always_comb begin
    s_d         = s_q;
    carry_d     = carry_q;
    out_valid_d = cpa_valid;
    if (cpa_valid) begin
      {carry_d, s_d} = sum_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_carry_save_adder3.sv
// Scoreboard bench for carry_save_adder3 (WIDTH=4); follows CSA_PIPE_EN for the expected latency.
module tb_carry_save_adder3;

  localparam int WIDTH = 4;
`ifdef CSA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  carry_save_adder3_if #(.WIDTH(WIDTH)) bus ();

  carry_save_adder3 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [5:0] sum;
    int         due;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] last_sum = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [5:0] e);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x = a;
    bus.y = b;
    bus.z = c;
    sb_q.push_back('{sum: e, due: cyc + LAT});
    last_sum = e;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x = 'x;
    bus.y = 'x;
    bus.z = 'x;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic hold_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("hold_out_valid", 32'(bus.out_valid), 32'd0);
      chk("hold_sum", 32'({bus.carry, bus.s}), 32'(last_sum));
    end
  endtask

  // Monitor: every presented result must match the oldest queued expectation at its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sum", 32'({bus.carry, bus.s}), 32'(e.sum));
          chk("latency", 32'(cyc), 32'(e.due));
          $display("result: carry=%0d s=%05b (sum %0d) at cycle %0d", bus.carry, bus.s,
                   {bus.carry, bus.s}, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  logic [3:0] sx[10] = '{4'd3, 4'd15, 4'd8, 4'd9,  4'd6,  4'd1, 4'd15, 4'd11, 4'd13, 4'd0};
  logic [3:0] sy[10] = '{4'd5, 4'd0,  4'd8, 4'd14, 4'd6,  4'd1, 4'd15, 4'd4,  4'd13, 4'd15};
  logic [3:0] sz[10] = '{4'd7, 4'd15, 4'd8, 4'd12, 4'd15, 4'd1, 4'd14, 4'd2,  4'd13, 4'd0};
  logic [5:0] se[10] = '{6'd15, 6'd30, 6'd24, 6'd35, 6'd27, 6'd3, 6'd44, 6'd17, 6'd39, 6'd15};

  initial begin
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.z = '0;

    #1;
    chk("reset_s", 32'(bus.s), 32'd0);
    chk("reset_carry", 32'(bus.carry), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(4'b1010, 4'b1010, 4'b1010, 6'd30);
    issue(4'b1111, 4'b1111, 4'b1111, 6'd45);
    issue(4'd1, 4'd2, 4'd4, 6'd7);
    issue(4'd0, 4'd0, 4'd0, 6'd0);
    idle();
    drain();

    for (int i = 0; i < 10; i++) issue(sx[i], sy[i], sz[i], se[i]);
    idle();
    drain();
    hold_check(3);

    // Reset between clock edges with a transaction in flight.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x = 4'd5;
    bus.y = 4'd6;
    bus.z = 4'd7;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_s", 32'(bus.s), 32'd0);
    chk("async_reset_carry", 32'(bus.carry), 32'd0);
    chk("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_sum = '0;
    hold_check(4);

    issue(4'b1111, 4'b1111, 4'b1111, 6'd45);
    idle();
    drain();
    hold_check(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
